id_stage_p: RTL
===============

Name: id_stage_p

Overview:
- Parametrised successor to the current MIPS instruction-decode stage; sits between the IF/ID and ID/EX pipeline registers.
- Holds an NREG x DW register file with write-back bypass.
- Fully decodes add/sub/slt/lw/sw/beq/j into control bits, immediates and targets.
- Adds valid/ready handshaking, flush, illegal-instruction flagging and load-use hazard stall with bubble insertion.

Parameters:
DW, 32, datapath width; legal values DW >= 32
AW, 5, register address width; NREG = 2**AW
PC_INC, 4, PC increment used for branch and jump targets

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  IR/PC hold a valid instruction
in_ready  out  1  stage accepts IR/PC this cycle
IR  in  32  instruction word
PC  in  DW  address of IR
flush  in  1  squash the ID/EX output next cycle (branch taken / jump)
wb_en  in  1  write-back enable
wb_rd  in  AW  write-back destination register
wb_data  in  DW  write-back data
ex_ready  in  1  EX stage accepts outputs this cycle
out_valid  out  1  outputs below are a valid instruction
A  out  DW  rs operand
B  out  DW  rt operand
IMM  out  DW  sign-extended IR[15:0]
RD  out  AW  destination register; 0 when none
ALUctr  out  3  0 add, 1 sub, 2 slt, 7 none
reg_wr, mem_rd, mem_wr, branch, jump  out  1 each  control bits
target  out  DW  branch or jump target
illegal  out  1  unknown opcode or funct

Behaviour:
- Reset (rst=1 at edge): all outputs, including out_valid and illegal, go to 0. All NREG registers are cleared to 0. Reset takes priority over all other inputs and aborts any stall.
- Register file:
  - Write happens when wb_en && wb_rd != 0; register 0 always reads 0.
  - Reads are combinational with write-first bypass: if wb_en && wb_rd != 0 && wb_rd == source, the operand is wb_data.
- Decode, by IR[31:26]:
  - 0 / funct 32, 34, 42 (add, sub, slt): RD = IR[15:11], reg_wr = 1, ALUctr = 0, 1, 2 respectively.
  - 35 (lw): RD = rt, reg_wr = 1, mem_rd = 1, ALUctr = 0.
  - 43 (sw): RD = 0, mem_wr = 1, ALUctr = 0.
  - 4 (beq): RD = 0, branch = 1, ALUctr = 1, target = PC + PC_INC + (IMM << 2) mod 2**DW.
  - 2 (j): RD = 0, jump = 1, ALUctr = 7, target = {(PC + PC_INC)[DW-1:28], IR[25:0], 2'b00}.
  - Anything else: illegal = 1, all control bits 0, RD = 0, ALUctr = 7, out_valid = 1 (so the trap propagates).
- uses_rt = R-type | sw | beq. A = REG[rs] and B = REG[rt] for every instruction.
- Hazard: stall = in_valid && out_valid && mem_rd && RD != 0 && (RD == rs || (uses_rt && RD == rt)), where mem_rd and RD are the current outputs.
- in_ready = !stall && (!out_valid || ex_ready).
- Output register update, in priority order:
  1. rst.
  2. flush: out_valid <= 0; the input is not consumed, in_ready is still computed as above, and the upstream stage flushes itself.
  3. out_valid && !ex_ready: hold all outputs.
  4. stall: bubble; out_valid <= 0 and control bits cleared, input held upstream.
  5. in_valid: load decoded fields, out_valid <= 1.
  6. Otherwise: out_valid <= 0.
- Latency: one cycle from accepted IR to out_valid.
- Simultaneous events:
  - Write-back to a register being read in the same cycle delivers the new value through the bypass.
  - A stall always resolves after exactly one bubble, because the lw moves to EX.

Test Plan:
- Reset, then wb writes 5 to r1 and 7 to r2; issue add r3,r1,r2 -> next cycle out_valid=1, A=5, B=7, RD=3, ALUctr=0, reg_wr=1.
- wb writes r1=9 in the same cycle add r3,r1,r1 is accepted -> A=B=9 via bypass; wb to r0 -> A reads 0.
- lw r4,8(r1) followed by sub r5,r4,r2 -> sub held one cycle (in_ready=0, bubble out_valid=0), then issued with RD=5, ALUctr=1.
- beq at PC=0x100, IMM=-2 -> target=0xFC, branch=1, RD=0; j 0x40 at PC=0x100 -> target=0x100, jump=1.
- ex_ready=0 for 3 cycles with a valid output -> outputs stable and in_ready=0; flush asserted during the hold -> out_valid=0 next cycle.
- Opcode 63 -> illegal=1, reg_wr=mem_wr=0; assert rst during a load-use stall -> all outputs 0 next cycle.

Source files
------------

// File: rtl/id_stage_p.sv
// MIPS instruction-decode stage: register file with write-back bypass, full decode
// of add/sub/slt/lw/sw/beq/j, valid/ready handshake, flush and load-use stall.
module id_stage_p #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int PC_INC = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   IR,
    input  logic [DW-1:0] PC,
    input  logic          flush,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_rd,
    input  logic [DW-1:0] wb_data,
    input  logic          ex_ready,
    output logic          out_valid,
    output logic [DW-1:0] A,
    output logic [DW-1:0] B,
    output logic [DW-1:0] IMM,
    output logic [AW-1:0] RD,
    output logic [2:0]    ALUctr,
    output logic          reg_wr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic          branch,
    output logic          jump,
    output logic [DW-1:0] target,
    output logic          illegal
);

    localparam int NREG = 2 ** AW;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_SUB   = 6'd34;
    localparam logic [5:0] FN_SLT   = 6'd42;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_SLT  = 3'd2,
        ALU_NONE = 3'd7
    } alu_e;

    logic [DW-1:0] regs [NREG];

    logic [5:0]    opcode;
    logic [5:0]    funct;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [DW-1:0] rs_val;
    logic [DW-1:0] rt_val;
    logic [DW-1:0] imm_ext;
    logic [DW-1:0] pc_inc;
    logic [DW-1:0] br_target;
    logic [DW-1:0] j_target;
    logic          unused_shamt;

    assign opcode       = IR[31:26];
    assign funct        = IR[5:0];
    assign rs           = AW'(IR[25:21]);
    assign rt           = AW'(IR[20:16]);
    assign unused_shamt = ^IR[10:6];

    // NOTE: the register file is a real reset target here, so every entry is cleared;
    // large memories normally stay unreset and are initialised by software instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_en && wb_rd != '0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Write-first bypass: a same-cycle write-back is visible to the reading instruction.
    assign rs_val = (rs == '0) ? '0 : (wb_en && wb_rd == rs) ? wb_data : regs[rs];
    assign rt_val = (rt == '0) ? '0 : (wb_en && wb_rd == rt) ? wb_data : regs[rt];

    assign imm_ext   = {{(DW-16){IR[15]}}, IR[15:0]};
    assign pc_inc    = PC + DW'(PC_INC);
    assign br_target = pc_inc + {imm_ext[DW-3:0], 2'b00};
    assign j_target  = {pc_inc[DW-1:28], IR[25:0], 2'b00};

    alu_e          d_alu;
    logic [AW-1:0] d_rd;
    logic          d_reg_wr;
    logic          d_mem_rd;
    logic          d_mem_wr;
    logic          d_branch;
    logic          d_jump;
    logic          d_illegal;
    logic [DW-1:0] d_target;
    logic          uses_rt;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        d_alu     = ALU_NONE;
        d_rd      = '0;
        d_reg_wr  = 1'b0;
        d_mem_rd  = 1'b0;
        d_mem_wr  = 1'b0;
        d_branch  = 1'b0;
        d_jump    = 1'b0;
        d_illegal = 1'b0;
        d_target  = '0;
        uses_rt   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                uses_rt = 1'b1;
                case (funct)
                    FN_ADD: begin d_rd = AW'(IR[15:11]); d_reg_wr = 1'b1; d_alu = ALU_ADD; end
                    FN_SUB: begin d_rd = AW'(IR[15:11]); d_reg_wr = 1'b1; d_alu = ALU_SUB; end
                    FN_SLT: begin d_rd = AW'(IR[15:11]); d_reg_wr = 1'b1; d_alu = ALU_SLT; end
                    default: d_illegal = 1'b1;
                endcase
            end
            OP_LW: begin
                d_rd     = rt;
                d_reg_wr = 1'b1;
                d_mem_rd = 1'b1;
                d_alu    = ALU_ADD;
            end
            OP_SW: begin
                uses_rt  = 1'b1;
                d_mem_wr = 1'b1;
                d_alu    = ALU_ADD;
            end
            OP_BEQ: begin
                uses_rt  = 1'b1;
                d_branch = 1'b1;
                d_alu    = ALU_SUB;
                d_target = br_target;
            end
            OP_J: begin
                d_jump   = 1'b1;
                d_target = j_target;
            end
            default: d_illegal = 1'b1;
        endcase
    end

    logic stall;

    // A load in ID/EX whose result the incoming instruction needs forces one bubble.
    assign stall = in_valid && out_valid && mem_rd && RD != '0 &&
                   (RD == rs || (uses_rt && RD == rt));
    assign in_ready = !stall && (!out_valid || ex_ready);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            A         <= '0;
            B         <= '0;
            IMM       <= '0;
            RD        <= '0;
            ALUctr    <= '0;
            reg_wr    <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            branch    <= 1'b0;
            jump      <= 1'b0;
            target    <= '0;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (!out_valid || ex_ready) begin
            if (stall) begin
                out_valid <= 1'b0;
                reg_wr    <= 1'b0;
                mem_rd    <= 1'b0;
                mem_wr    <= 1'b0;
                branch    <= 1'b0;
                jump      <= 1'b0;
                illegal   <= 1'b0;
            end else if (in_valid) begin
                out_valid <= 1'b1;
                A         <= rs_val;
                B         <= rt_val;
                IMM       <= imm_ext;
                RD        <= d_rd;
                ALUctr    <= d_alu;
                reg_wr    <= d_reg_wr;
                mem_rd    <= d_mem_rd;
                mem_wr    <= d_mem_wr;
                branch    <= d_branch;
                jump      <= d_jump;
                target    <= d_target;
                illegal   <= d_illegal;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
